// File: rtl/controller_pkg.sv
// Shared controller definitions: instruction store geometry, loader states and
// checksum width.
package controller_pkg;

    localparam int INSTR_ADDR_WIDTH = 13;
    localparam int INSTR_DEPTH      = 8192;
    localparam int CSUM_WIDTH       = 32;

    typedef enum logic [2:0] {
        LD_IDLE    = 3'd0,
        LD_COLLECT = 3'd1,
        LD_WRITE   = 3'd2,
        LD_VERIFY  = 3'd3,
        LD_DONE    = 3'd4
    } loader_state_t;

endpackage

// File: rtl/byte_word_packer.sv
// Little-endian 8->32 assembler: the first accepted byte lands in bits 7:0 and
// the fourth in bits 31:24. word_ready flags the fourth byte of each word.
module byte_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [1:0] byte_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (accept) begin
            word     <= {in_data, word[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    assign word_ready = accept && (byte_cnt == 2'd3);

endmodule

// File: rtl/instruction_rom_loader.sv
// Avalon-MM initiator that loads the instruction RAM from a byte stream.
// Define INSTRUCTION_LOADER_VERIFY_EN to add read-back checksum verification.
module instruction_rom_loader
    import controller_pkg::*;
#(
    parameter int ADDR_WIDTH = INSTR_ADDR_WIDTH,
    parameter int DEPTH      = INSTR_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic                  avm_chipselect,
    output logic                  avm_write,
    output logic [3:0]            avm_byteenable,
    output logic [31:0]           avm_writedata,
    output logic                  avm_debugaccess,
    output logic                  avm_clken,
    input  logic [31:0]           avm_readdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int CW = ADDR_WIDTH + 1;

    loader_state_t state, state_nxt;
    logic [CW-1:0] wc_q;
    logic [CW-1:0] addr_q;
    logic          err_q;
    logic [31:0]   word;
    logic          word_ready;
    logic          accept;
    logic          last_wr;
    logic          bad_count;
    logic          zero_count;

    assign accept     = in_valid && in_ready;
    assign last_wr    = (addr_q + CW'(1)) == wc_q;
    assign zero_count = (word_count == '0);
    assign bad_count  = (word_count > CW'(DEPTH));

    byte_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (state == LD_IDLE && start),
        .accept     (accept),
        .in_data    (in_data),
        .word       (word),
        .word_ready (word_ready)
    );

`ifdef INSTRUCTION_LOADER_VERIFY_EN
    logic [CSUM_WIDTH-1:0] wr_sum;
    logic [CSUM_WIDTH-1:0] rd_sum;
    logic                  rd_pend;
    logic                  rd_issue;
    logic                  rd_last;

    assign rd_issue = (addr_q != wc_q);
    assign rd_last  = (state == LD_VERIFY) && !rd_issue;
`else
    logic unused_rd;
    assign unused_rd = ^avm_readdata;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LD_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LD_IDLE: begin
                if (start) state_nxt = (zero_count || bad_count) ? LD_DONE : LD_COLLECT;
            end
            LD_COLLECT: begin
                if (word_ready) state_nxt = LD_WRITE;
            end
            LD_WRITE: begin
`ifdef INSTRUCTION_LOADER_VERIFY_EN
                if (last_wr) state_nxt = LD_VERIFY;
`else
                if (last_wr) state_nxt = LD_DONE;
`endif
                else         state_nxt = LD_COLLECT;
            end
`ifdef INSTRUCTION_LOADER_VERIFY_EN
            LD_VERIFY: begin
                if (rd_last) state_nxt = LD_DONE;
            end
`endif
            LD_DONE:  state_nxt = LD_IDLE;
            default:  state_nxt = LD_IDLE;
        endcase
    end

    // Address counter doubles as the write pointer and, after the last write,
    // as the verify read pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wc_q   <= '0;
            addr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                LD_IDLE: begin
                    if (start) begin
                        wc_q   <= word_count;
                        addr_q <= '0;
                        err_q  <= bad_count;
                    end
                end
                LD_WRITE: begin
`ifdef INSTRUCTION_LOADER_VERIFY_EN
                    addr_q <= last_wr ? '0 : addr_q + CW'(1);
`else
                    addr_q <= addr_q + CW'(1);
`endif
                end
`ifdef INSTRUCTION_LOADER_VERIFY_EN
                LD_VERIFY: begin
                    if (rd_issue) addr_q <= addr_q + CW'(1);
                    if (rd_last && ((rd_sum + avm_readdata) != wr_sum)) err_q <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef INSTRUCTION_LOADER_VERIFY_EN
    // Read data lags its address by one cycle; rd_pend marks a cycle that
    // carries returned data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_sum  <= '0;
            rd_sum  <= '0;
            rd_pend <= 1'b0;
        end else begin
            case (state)
                LD_IDLE: begin
                    if (start) begin
                        wr_sum  <= '0;
                        rd_sum  <= '0;
                        rd_pend <= 1'b0;
                    end
                end
                LD_WRITE: wr_sum <= wr_sum + word;
                LD_VERIFY: begin
                    rd_pend <= rd_issue;
                    if (rd_pend) rd_sum <= rd_sum + avm_readdata;
                end
                default: ;
            endcase
        end
    end
`endif

    always_comb begin
        in_ready        = (state == LD_COLLECT);
        busy            = (state == LD_COLLECT) || (state == LD_WRITE) || (state == LD_VERIFY);
        done            = (state == LD_DONE);
        avm_write       = (state == LD_WRITE);
        avm_chipselect  = (state == LD_WRITE);
`ifdef INSTRUCTION_LOADER_VERIFY_EN
        if (state == LD_VERIFY) avm_chipselect = rd_issue;
`endif
        avm_writedata   = (state == LD_WRITE) ? word : '0;
        avm_address     = addr_q[ADDR_WIDTH-1:0];
        avm_byteenable  = busy ? 4'hF : 4'h0;
        avm_debugaccess = busy;
        avm_clken       = busy;
        error           = err_q;
    end

endmodule

// File: tb/tb_instruction_rom_loader.sv
// Bench for instruction_rom_loader: RAM model, table of load scenarios with
// random byte streams, plus reset-mid-load and directed sequences.
module tb_instruction_rom_loader;

    localparam int AW    = 13;
    localparam int DEPTH = 8192;
`ifdef INSTRUCTION_LOADER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   word_count = '0;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] avm_address;
    logic          avm_chipselect, avm_write;
    logic [3:0]    avm_byteenable;
    logic [31:0]   avm_writedata;
    logic          avm_debugaccess, avm_clken;
    logic [31:0]   avm_readdata = '0;
    logic          busy, done, error;

    always #5 clk = ~clk;

    instruction_rom_loader dut (
        .clk(clk), .reset(reset), .start(start), .word_count(word_count),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write(avm_write), .avm_byteenable(avm_byteenable),
        .avm_writedata(avm_writedata), .avm_debugaccess(avm_debugaccess),
        .avm_clken(avm_clken), .avm_readdata(avm_readdata),
        .busy(busy), .done(done), .error(error)
    );

    // RAM model: one-cycle read latency, optional corruption of one word on read
    logic [31:0] mem [DEPTH];
    int corrupt_addr = -1;
    always @(posedge clk) begin
        if (avm_chipselect && avm_write) mem[avm_address] <= avm_writedata;
        if (avm_chipselect && !avm_write)
            avm_readdata <= mem[avm_address] ^ ((int'(avm_address) == corrupt_addr) ? 32'h1 : 32'h0);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int addr; logic [31:0] data; } wr_t;
    wr_t  wr_q[$];
    int   n_rd, n_rd_bad, n_be_bad, n_done, done_cyc;
    logic err_at_done;

    always @(negedge clk) begin
        if (avm_chipselect && avm_write) begin
            wr_q.push_back('{int'(avm_address), avm_writedata});
            if (avm_byteenable != 4'hF) n_be_bad++;
        end
        if (avm_chipselect && !avm_write) begin
            if (int'(avm_address) != n_rd) n_rd_bad++;
            n_rd++;
        end
        if (done) begin
            done_cyc    = cyc;
            err_at_done = error;
            n_done++;
        end
    end

    int vectors = 0, miscompares = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {7'd0, in_ready, avm_address, avm_chipselect, avm_write, avm_byteenable,
                avm_writedata, avm_debugaccess, avm_clken, busy, done, error};
    endfunction

    logic [7:0] bytes[$];

    // pat: 0 random, 1 incrementing, 2 fixed 78 56 34 12; gap: 0 none, 1 alternate, 2 random
    task automatic run_load(input int wc, input int pat, input int gap, input bit mid, input bit corrupt);
        int   nb, idx, stall, s_cyc, hs_cyc, t, bad;
        bit   valid, pulsed, exp_err;
        logic [31:0] exp_w;
        wr_q.delete();
        n_rd = 0; n_rd_bad = 0; n_be_bad = 0; n_done = 0; done_cyc = -100000; err_at_done = 1'bx;
        corrupt_addr = corrupt ? 5 : -1;
        valid   = (wc >= 1) && (wc <= DEPTH);
        exp_err = (wc > DEPTH) || (VERIFY && corrupt && valid && wc > 5);
        nb = valid ? wc * 4 : 0;
        bytes.delete();
        for (int i = 0; i < nb; i++) begin
            if (pat == 1)      bytes.push_back(8'(i));
            else if (pat == 2) bytes.push_back(8'(8'h78 - 8'(i) * 8'h22));
            else               bytes.push_back(8'($urandom));
        end
        @(negedge clk);
        start = 1'b1; word_count = (AW+1)'(wc); s_cyc = cyc;
        @(negedge clk);
        start = 1'b0; word_count = (AW+1)'($urandom);
        check($sformatf("busy rise wc=%0d", wc), {63'd0, busy}, {63'd0, valid});
        idx = 0; stall = 0; pulsed = 0; hs_cyc = -100000;
        while (idx < nb && stall < 100) begin
            in_valid = (gap == 0) ? 1'b1 : (gap == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            in_data  = in_valid ? bytes[idx] : 8'($urandom);
            if (mid && idx == 6 && !pulsed) begin
                start = 1'b1; word_count = (AW+1)'($urandom_range(1, 20)); pulsed = 1;
            end else begin
                start = 1'b0;
            end
            if (in_valid && in_ready) begin hs_cyc = cyc; idx++; stall = 0; end
            else stall++;
            @(negedge clk);
        end
        in_valid = 1'b0; start = 1'b0;
        #1;
        t = 0;
        while (n_done == 0 && t < wc + 100) begin @(negedge clk); #1; t++; end
        check($sformatf("done latency wc=%0d", wc),
              valid ? 64'(done_cyc - hs_cyc) : 64'(done_cyc - s_cyc),
              valid ? (VERIFY ? 64'(wc + 3) : 64'd2) : 64'd1);
        check($sformatf("write count wc=%0d", wc), 64'(wr_q.size()), 64'(valid ? wc : 0));
        bad = 0;
        foreach (wr_q[i]) begin
            exp_w = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
            if (wr_q[i].addr != i || wr_q[i].data !== exp_w) bad++;
        end
        check($sformatf("write data wc=%0d", wc), 64'(bad), 64'd0);
        check($sformatf("byteenable wc=%0d", wc), 64'(n_be_bad), 64'd0);
        check($sformatf("reads wc=%0d", wc), {32'(n_rd), 32'(n_rd_bad)},
              {32'((VERIFY && valid) ? wc : 0), 32'd0});
        check($sformatf("error at done wc=%0d", wc), {63'd0, err_at_done}, {63'd0, exp_err});
        repeat (3) @(negedge clk);
        #1;
        check($sformatf("sticky error/idle wc=%0d", wc), {61'd0, error, busy, done}, {61'd0, exp_err, 2'b00});
        check($sformatf("single done wc=%0d", wc), 64'(n_done), 64'd1);
    endtask

    typedef struct { int wc; int pat; int gap; bit mid; bit corrupt; } vec_t;
    vec_t tbl[8];

    initial begin
        int idx, t;
        tbl[0] = '{0,    0, 0, 0, 0};
        tbl[1] = '{8193, 0, 0, 0, 0};
        tbl[2] = '{3,    0, 0, 0, 0};
        tbl[3] = '{5,    0, 2, 0, 0};
        tbl[4] = '{4,    0, 1, 1, 0};
        tbl[5] = '{DEPTH,1, 0, 0, 0};
        tbl[6] = '{16,   0, 2, 0, 1};
        tbl[7] = '{7,    1, 1, 0, 0};

        #12;
        check("reset outputs", outs(), 64'd0);
        @(negedge clk); reset = 1'b0;

        run_load(1, 2, 0, 0, 0);
        check("directed word", (wr_q.size() == 1) ? {32'(wr_q[0].addr), wr_q[0].data} : 64'hDEAD,
              {32'd0, 32'h12345678});

        for (int i = 0; i < 8; i++) begin
            run_load(tbl[i].wc, tbl[i].pat, tbl[i].gap, tbl[i].mid, tbl[i].corrupt);
            if (tbl[i].wc == DEPTH)
                check("last address", (wr_q.size() > 0) ? 64'(wr_q[wr_q.size()-1].addr) : 64'hDEAD,
                      64'h1FFF);
        end

        // Reset in the middle of the second word of a four-word load
        @(negedge clk); start = 1'b1; word_count = 14'd4;
        @(negedge clk); start = 1'b0;
        idx = 0; t = 0;
        while (idx < 6 && t < 100) begin
            in_valid = 1'b1; in_data = 8'($urandom);
            if (in_ready) idx++;
            t++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bytes before reset", 64'(idx), 64'd6);
        reset = 1'b1;
        #1;
        check("reset mid-load outputs", outs(), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_load(1, 0, 2, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
